// File: rtl/mips_pkg.sv
// Shared MIPS multicycle constants: opcodes, functs, ALU operation codes and controller state codes.
// Pure declarations; no timing or flow-control behaviour of its own.
package mips_pkg;

    localparam int ALU_OP_W = 4;

    typedef enum logic [3:0] {
        ST_IF     = 4'd0,
        ST_ID     = 4'd1,
        ST_EX_R   = 4'd2,
        ST_EX_I   = 4'd3,
        ST_BR     = 4'd4,
        ST_MEM_RD = 4'd5,
        ST_MEM_WR = 4'd6,
        ST_WB_R   = 4'd7,
        ST_WB_I   = 4'd8,
        ST_WB_MEM = 4'd9,
        ST_JR     = 4'd10,
        ST_EXC    = 4'd11
    } state_t;

    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_J     = 6'h02;
    localparam logic [5:0] OP_JAL   = 6'h03;
    localparam logic [5:0] OP_BEQ   = 6'h04;
    localparam logic [5:0] OP_BNE   = 6'h05;
    localparam logic [5:0] OP_ADDI  = 6'h08;
    localparam logic [5:0] OP_ADDIU = 6'h09;
    localparam logic [5:0] OP_SLTI  = 6'h0A;
    localparam logic [5:0] OP_SLTIU = 6'h0B;
    localparam logic [5:0] OP_ANDI  = 6'h0C;
    localparam logic [5:0] OP_ORI   = 6'h0D;
    localparam logic [5:0] OP_XORI  = 6'h0E;
    localparam logic [5:0] OP_LUI   = 6'h0F;
    localparam logic [5:0] OP_LW    = 6'h23;
    localparam logic [5:0] OP_SW    = 6'h2B;

    localparam logic [5:0] FN_SLL  = 6'h00;
    localparam logic [5:0] FN_SRL  = 6'h02;
    localparam logic [5:0] FN_SRA  = 6'h03;
    localparam logic [5:0] FN_JR   = 6'h08;
    localparam logic [5:0] FN_JALR = 6'h09;
    localparam logic [5:0] FN_ADDU = 6'h21;
    localparam logic [5:0] FN_SUBU = 6'h23;
    localparam logic [5:0] FN_AND  = 6'h24;
    localparam logic [5:0] FN_OR   = 6'h25;
    localparam logic [5:0] FN_XOR  = 6'h26;
    localparam logic [5:0] FN_NOR  = 6'h27;
    localparam logic [5:0] FN_SLT  = 6'h2A;
    localparam logic [5:0] FN_SLTU = 6'h2B;

    localparam logic [ALU_OP_W-1:0] ALU_ADDU = 4'd0;
    localparam logic [ALU_OP_W-1:0] ALU_SUBU = 4'd1;
    localparam logic [ALU_OP_W-1:0] ALU_AND  = 4'd2;
    localparam logic [ALU_OP_W-1:0] ALU_OR   = 4'd3;
    localparam logic [ALU_OP_W-1:0] ALU_XOR  = 4'd4;
    localparam logic [ALU_OP_W-1:0] ALU_NOR  = 4'd5;
    localparam logic [ALU_OP_W-1:0] ALU_SLT  = 4'd6;
    localparam logic [ALU_OP_W-1:0] ALU_SLTU = 4'd7;
    localparam logic [ALU_OP_W-1:0] ALU_SLL  = 4'd8;
    localparam logic [ALU_OP_W-1:0] ALU_SRL  = 4'd9;
    localparam logic [ALU_OP_W-1:0] ALU_SRA  = 4'd10;
    localparam logic [ALU_OP_W-1:0] ALU_LUI  = 4'd11;

    function automatic logic is_alu_imm(input logic [5:0] op);
        return (op == OP_ADDI)  || (op == OP_ADDIU) || (op == OP_SLTI) ||
               (op == OP_SLTIU) || (op == OP_ANDI)  || (op == OP_ORI)  ||
               (op == OP_XORI)  || (op == OP_LUI);
    endfunction

    // Logical immediates take a zero-extended operand; everything else sign-extends.
    function automatic logic is_logic_imm(input logic [5:0] op);
        return (op == OP_ANDI) || (op == OP_ORI) || (op == OP_XORI);
    endfunction

endpackage

// File: rtl/mc_ctrl_hs_alu_dec.sv
// ALU operation decoder: funct (R path) or opcode (I path) to ALU op code.
// Purely combinational, zero latency; no flow control.
module alu_dec
    import mips_pkg::*;
(
    input  logic                r_path,
    input  logic [5:0]          opcode,
    input  logic [5:0]          funct,
    output logic [ALU_OP_W-1:0] alu_op
);

    always_comb begin
        alu_op = ALU_ADDU;
        if (r_path) begin
            case (funct)
                FN_ADDU: alu_op = ALU_ADDU;
                FN_SUBU: alu_op = ALU_SUBU;
                FN_AND:  alu_op = ALU_AND;
                FN_OR:   alu_op = ALU_OR;
                FN_XOR:  alu_op = ALU_XOR;
                FN_NOR:  alu_op = ALU_NOR;
                FN_SLT:  alu_op = ALU_SLT;
                FN_SLTU: alu_op = ALU_SLTU;
                FN_SLL:  alu_op = ALU_SLL;
                FN_SRL:  alu_op = ALU_SRL;
                FN_SRA:  alu_op = ALU_SRA;
                default: alu_op = ALU_ADDU;
            endcase
        end else begin
            case (opcode)
                OP_LUI:   alu_op = ALU_LUI;
                OP_ANDI:  alu_op = ALU_AND;
                OP_ORI:   alu_op = ALU_OR;
                OP_XORI:  alu_op = ALU_XOR;
                OP_SLTI:  alu_op = ALU_SLT;
                OP_SLTIU: alu_op = ALU_SLTU;
                default:  alu_op = ALU_ADDU;
            endcase
        end
    end

endmodule

// File: rtl/mc_ctrl_hs.sv
// Multicycle MIPS control FSM with memory handshake; 3-5 cycles per instruction plus one per wait cycle.
// mem_ready low holds IF, MEM_RD or MEM_WR with the request asserted; all outputs forced low in reset.
module mc_ctrl_hs
    import mips_pkg::*;
#(
    parameter int ALUOP_W = 4,
    parameter bit EN_EXC  = 1'b1
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [5:0]         opcode,
    input  logic [5:0]         funct,
    input  logic               mem_ready,
    output logic               mem_req,
    output logic [ALUOP_W-1:0] ALUOp,
    output logic               MemRead,
    output logic               MemWrite,
    output logic               IRWrite,
    output logic               RegDst,
    output logic               RegWrite,
    output logic               ALUSrcA,
    output logic               MemtoReg,
    output logic               PCWrite,
    output logic               PCWriteCond,
    output logic               IorD,
    output logic               SignExtend,
    output logic               SavePC,
    output logic [1:0]         ALUSrcB,
    output logic [1:0]         PCSource,
    output logic               exc,
    output logic [3:0]         state
);

    state_t cur, nxt;

    logic [ALU_OP_W-1:0] alu_r;
    logic [ALU_OP_W-1:0] alu_i;
    logic [ALU_OP_W-1:0] alu_sel;

    logic is_r, is_jr_fn, is_lw, is_sw, is_br, is_j, is_imm;

    alu_dec u_alu_dec_r (
        .r_path (1'b1),
        .opcode (opcode),
        .funct  (funct),
        .alu_op (alu_r)
    );

    alu_dec u_alu_dec_i (
        .r_path (1'b0),
        .opcode (opcode),
        .funct  (funct),
        .alu_op (alu_i)
    );

    assign is_r     = (opcode == OP_RTYPE);
    assign is_jr_fn = (funct == FN_JR) || (funct == FN_JALR);
    assign is_lw    = (opcode == OP_LW);
    assign is_sw    = (opcode == OP_SW);
    assign is_br    = (opcode == OP_BEQ) || (opcode == OP_BNE);
    assign is_j     = (opcode == OP_J) || (opcode == OP_JAL);
    assign is_imm   = is_alu_imm(opcode);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cur <= ST_IF;
        end else begin
            cur <= nxt;
        end
    end

    assign state = cur;
    assign ALUOp = ALUOP_W'(alu_sel);

    always_comb begin
        nxt         = ST_IF;
        alu_sel     = ALU_ADDU;
        mem_req     = 1'b0;
        MemRead     = 1'b0;
        MemWrite    = 1'b0;
        IRWrite     = 1'b0;
        RegDst      = 1'b0;
        RegWrite    = 1'b0;
        ALUSrcA     = 1'b0;
        MemtoReg    = 1'b0;
        PCWrite     = 1'b0;
        PCWriteCond = 1'b0;
        IorD        = 1'b0;
        SignExtend  = 1'b0;
        SavePC      = 1'b0;
        ALUSrcB     = 2'b00;
        PCSource    = 2'b00;
        exc         = 1'b0;

        // Reset overrides every output while asserted, not only the state register.
        if (!rst) begin
            case (cur)
                ST_IF: begin
                    mem_req = 1'b1;
                    MemRead = 1'b1;
                    alu_sel = ALU_ADDU;
                    ALUSrcB = 2'b01;
                    if (mem_ready) begin
                        IRWrite = 1'b1;
                        PCWrite = 1'b1;
                        nxt     = ST_ID;
                    end else begin
                        nxt = ST_IF;
                    end
                end

                ST_ID: begin
                    alu_sel    = ALU_ADDU;
                    ALUSrcB    = 2'b11;
                    SignExtend = 1'b1;
                    if (is_r) begin
                        nxt = is_jr_fn ? ST_JR : ST_EX_R;
                    end else if (is_lw || is_sw || is_imm) begin
                        nxt = ST_EX_I;
                    end else if (is_br) begin
                        nxt = ST_BR;
                    end else if (is_j) begin
                        PCSource = 2'b10;
                        PCWrite  = 1'b1;
                        nxt      = ST_WB_I;
                    end else begin
                        nxt = EN_EXC ? ST_EXC : ST_EX_I;
                    end
                end

                ST_EX_R: begin
                    ALUSrcA = 1'b1;
                    alu_sel = alu_r;
                    nxt     = ST_WB_R;
                end

                ST_EX_I: begin
                    ALUSrcA    = 1'b1;
                    ALUSrcB    = 2'b10;
                    SignExtend = !is_logic_imm(opcode);
                    alu_sel    = alu_i;
                    if (is_lw) begin
                        nxt = ST_MEM_RD;
                    end else if (is_sw) begin
                        nxt = ST_MEM_WR;
                    end else begin
                        nxt = ST_WB_I;
                    end
                end

                // Zero flag polarity for BEQ versus BNE is applied in the datapath.
                ST_BR: begin
                    ALUSrcA     = 1'b1;
                    ALUSrcB     = 2'b00;
                    alu_sel     = ALU_SUBU;
                    PCSource    = 2'b01;
                    PCWriteCond = 1'b1;
                    nxt         = ST_IF;
                end

                ST_MEM_RD: begin
                    mem_req = 1'b1;
                    MemRead = 1'b1;
                    IorD    = 1'b1;
                    nxt     = mem_ready ? ST_WB_MEM : ST_MEM_RD;
                end

                ST_MEM_WR: begin
                    mem_req  = 1'b1;
                    MemWrite = 1'b1;
                    IorD     = 1'b1;
                    nxt      = mem_ready ? ST_IF : ST_MEM_WR;
                end

                ST_WB_R: begin
                    RegDst   = 1'b1;
                    RegWrite = 1'b1;
                    nxt      = ST_IF;
                end

                ST_WB_MEM: begin
                    RegWrite = 1'b1;
                    MemtoReg = 1'b1;
                    nxt      = ST_IF;
                end

                ST_WB_I: begin
                    RegWrite = (opcode != OP_J);
                    SavePC   = (opcode == OP_JAL);
                    nxt      = ST_IF;
                end

                ST_JR: begin
                    ALUSrcA  = 1'b1;
                    PCSource = 2'b01;
                    PCWrite  = 1'b1;
                    if (funct == FN_JALR) begin
                        RegDst   = 1'b1;
                        RegWrite = 1'b1;
                        SavePC   = 1'b1;
                    end
                    nxt = ST_IF;
                end

                ST_EXC: begin
                    exc      = 1'b1;
                    PCSource = 2'b11;
                    PCWrite  = 1'b1;
                    nxt      = ST_IF;
                end

                default: begin
                    nxt = ST_IF;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mc_ctrl_hs.sv
// Scoreboard bench for mc_ctrl_hs: directed instructions push per-cycle expectations, a monitor compares them.
module tb_mc_ctrl_hs;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [5:0] opcode = 6'h00;
    logic [5:0] funct = 6'h00;
    logic       mem_ready = 1'b0;

    // Outputs of the EN_EXC=1 instance (a_) and the EN_EXC=0 instance (b_).
    logic       a_mem_req, a_MemRead, a_MemWrite, a_IRWrite, a_RegDst, a_RegWrite, a_ALUSrcA;
    logic       a_MemtoReg, a_PCWrite, a_PCWriteCond, a_IorD, a_SignExtend, a_SavePC, a_exc;
    logic [1:0] a_ALUSrcB, a_PCSource;
    logic [3:0] a_ALUOp, a_state;
    logic       b_mem_req, b_MemRead, b_MemWrite, b_IRWrite, b_RegDst, b_RegWrite, b_ALUSrcA;
    logic       b_MemtoReg, b_PCWrite, b_PCWriteCond, b_IorD, b_SignExtend, b_SavePC, b_exc;
    logic [1:0] b_ALUSrcB, b_PCSource;
    logic [3:0] b_ALUOp, b_state;

    mc_ctrl_hs #(.ALUOP_W(4), .EN_EXC(1'b1)) dut (
        .clk(clk), .rst(rst), .opcode(opcode), .funct(funct), .mem_ready(mem_ready),
        .mem_req(a_mem_req), .ALUOp(a_ALUOp), .MemRead(a_MemRead), .MemWrite(a_MemWrite),
        .IRWrite(a_IRWrite), .RegDst(a_RegDst), .RegWrite(a_RegWrite), .ALUSrcA(a_ALUSrcA),
        .MemtoReg(a_MemtoReg), .PCWrite(a_PCWrite), .PCWriteCond(a_PCWriteCond), .IorD(a_IorD),
        .SignExtend(a_SignExtend), .SavePC(a_SavePC), .ALUSrcB(a_ALUSrcB), .PCSource(a_PCSource),
        .exc(a_exc), .state(a_state)
    );

    mc_ctrl_hs #(.ALUOP_W(4), .EN_EXC(1'b0)) dut_noexc (
        .clk(clk), .rst(rst), .opcode(opcode), .funct(funct), .mem_ready(mem_ready),
        .mem_req(b_mem_req), .ALUOp(b_ALUOp), .MemRead(b_MemRead), .MemWrite(b_MemWrite),
        .IRWrite(b_IRWrite), .RegDst(b_RegDst), .RegWrite(b_RegWrite), .ALUSrcA(b_ALUSrcA),
        .MemtoReg(b_MemtoReg), .PCWrite(b_PCWrite), .PCWriteCond(b_PCWriteCond), .IorD(b_IorD),
        .SignExtend(b_SignExtend), .SavePC(b_SavePC), .ALUSrcB(b_ALUSrcB), .PCSource(b_PCSource),
        .exc(b_exc), .state(b_state)
    );

    always #5 clk = ~clk;

    logic [21:0] a_vec, b_vec;
    assign a_vec = {a_mem_req, a_MemRead, a_MemWrite, a_IRWrite, a_RegDst, a_RegWrite, a_ALUSrcA,
                    a_MemtoReg, a_PCWrite, a_PCWriteCond, a_IorD, a_SignExtend, a_SavePC, a_exc,
                    a_ALUSrcB, a_PCSource, a_ALUOp};
    assign b_vec = {b_mem_req, b_MemRead, b_MemWrite, b_IRWrite, b_RegDst, b_RegWrite, b_ALUSrcA,
                    b_MemtoReg, b_PCWrite, b_PCWriteCond, b_IorD, b_SignExtend, b_SavePC, b_exc,
                    b_ALUSrcB, b_PCSource, b_ALUOp};

    localparam logic [21:0] REQ  = 22'd1 << 21;
    localparam logic [21:0] MRD  = 22'd1 << 20;
    localparam logic [21:0] MWR  = 22'd1 << 19;
    localparam logic [21:0] IRW  = 22'd1 << 18;
    localparam logic [21:0] RDST = 22'd1 << 17;
    localparam logic [21:0] RW   = 22'd1 << 16;
    localparam logic [21:0] SRCA = 22'd1 << 15;
    localparam logic [21:0] M2R  = 22'd1 << 14;
    localparam logic [21:0] PCW  = 22'd1 << 13;
    localparam logic [21:0] PWC  = 22'd1 << 12;
    localparam logic [21:0] IORD = 22'd1 << 11;
    localparam logic [21:0] SEXT = 22'd1 << 10;
    localparam logic [21:0] SPC  = 22'd1 << 9;
    localparam logic [21:0] EXC  = 22'd1 << 8;

    function automatic logic [21:0] sb(input logic [1:0] v);
        return 22'(v) << 6;
    endfunction
    function automatic logic [21:0] ps(input logic [1:0] v);
        return 22'(v) << 4;
    endfunction
    function automatic logic [21:0] alu(input logic [3:0] v);
        return 22'(v);
    endfunction

    logic [21:0] v_if_go, v_if_wait, v_id, v_exi_se;
    initial begin
        v_if_go   = REQ | MRD | IRW | PCW | sb(2'b01);
        v_if_wait = REQ | MRD | sb(2'b01);
        v_id      = sb(2'b11) | SEXT;
        v_exi_se  = SRCA | sb(2'b10) | SEXT;
    end

    typedef struct {
        string       nm;
        bit          sel;
        logic [3:0]  st;
        logic [21:0] v;
    } exp_t;

    exp_t exp_q[$];
    exp_t e;
    int   n_chk  = 0;
    int   n_fail = 0;

    always @(negedge clk) begin
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            n_chk++;
            if ((e.sel ? b_state : a_state) !== e.st) begin
                n_fail++;
                $display("FAIL %s state: got %0d, want %0d", e.nm, e.sel ? b_state : a_state, e.st);
            end
            n_chk++;
            if ((e.sel ? b_vec : a_vec) !== e.v) begin
                n_fail++;
                $display("FAIL %s outputs: got %06h, want %06h", e.nm, e.sel ? b_vec : a_vec, e.v);
            end
        end
    end

    task automatic step(input logic [5:0] op, input logic [5:0] fn, input logic rdy,
                        input logic [3:0] st, input logic [21:0] v, input string nm);
        opcode    = op;
        funct     = fn;
        mem_ready = rdy;
        exp_q.push_back('{nm, 1'b0, st, v});
        @(posedge clk);
        #1;
    endtask

    task automatic step2(input logic [5:0] op, input logic rdy,
                         input logic [3:0] st_a, input logic [21:0] v_a,
                         input logic [3:0] st_b, input logic [21:0] v_b, input string nm);
        opcode    = op;
        funct     = 6'h00;
        mem_ready = rdy;
        exp_q.push_back('{{nm, "_exc1"}, 1'b0, st_a, v_a});
        exp_q.push_back('{{nm, "_exc0"}, 1'b1, st_b, v_b});
        @(posedge clk);
        #1;
    endtask

    task automatic rtype(input logic [5:0] fn, input logic [3:0] aop, input string nm);
        step(6'h00, fn, 1'b1, 4'd0, v_if_go, {nm, "_if"});
        step(6'h00, fn, 1'b1, 4'd1, v_id, {nm, "_id"});
        step(6'h00, fn, 1'b1, 4'd2, SRCA | alu(aop), {nm, "_ex"});
        step(6'h00, fn, 1'b1, 4'd7, RDST | RW, {nm, "_wb"});
    endtask

    initial begin
        @(posedge clk);
        #1;
        // Outputs stay low in reset even with a fetch-ready memory.
        step(6'h00, 6'h21, 1'b1, 4'd0, 22'd0, "rst_hold_a");
        step(6'h23, 6'h00, 1'b1, 4'd0, 22'd0, "rst_hold_b");
        rst = 1'b0;

        rtype(6'h21, 4'd0, "addu");
        rtype(6'h27, 4'd5, "nor");
        rtype(6'h03, 4'd10, "sra");
        rtype(6'h2A, 4'd6, "slt");

        // LW with three wait cycles in MEM_RD: eight cycles total.
        step(6'h23, 6'h00, 1'b1, 4'd0, v_if_go, "lw_if");
        step(6'h23, 6'h00, 1'b1, 4'd1, v_id, "lw_id");
        step(6'h23, 6'h00, 1'b1, 4'd3, v_exi_se, "lw_ex");
        for (int i = 0; i < 3; i++) begin
            step(6'h23, 6'h00, 1'b0, 4'd5, REQ | MRD | IORD, "lw_memrd_wait");
        end
        step(6'h23, 6'h00, 1'b1, 4'd5, REQ | MRD | IORD, "lw_memrd_go");
        step(6'h23, 6'h00, 1'b1, 4'd9, RW | M2R, "lw_wbmem");

        // SW with a fetch wait and a store wait.
        step(6'h2B, 6'h00, 1'b0, 4'd0, v_if_wait, "sw_if_wait");
        step(6'h2B, 6'h00, 1'b1, 4'd0, v_if_go, "sw_if");
        step(6'h2B, 6'h00, 1'b1, 4'd1, v_id, "sw_id");
        step(6'h2B, 6'h00, 1'b1, 4'd3, v_exi_se, "sw_ex");
        step(6'h2B, 6'h00, 1'b0, 4'd6, REQ | MWR | IORD, "sw_memwr_wait");
        step(6'h2B, 6'h00, 1'b1, 4'd6, REQ | MWR | IORD, "sw_memwr_go");

        // ORI: zero-extended immediate, OR op.
        step(6'h0D, 6'h00, 1'b1, 4'd0, v_if_go, "ori_if");
        step(6'h0D, 6'h00, 1'b1, 4'd1, v_id, "ori_id");
        step(6'h0D, 6'h00, 1'b1, 4'd3, SRCA | sb(2'b10) | alu(4'd3), "ori_ex");
        step(6'h0D, 6'h00, 1'b1, 4'd8, RW, "ori_wb");

        step(6'h0F, 6'h00, 1'b1, 4'd0, v_if_go, "lui_if");
        step(6'h0F, 6'h00, 1'b1, 4'd1, v_id, "lui_id");
        step(6'h0F, 6'h00, 1'b1, 4'd3, v_exi_se | alu(4'd11), "lui_ex");
        step(6'h0F, 6'h00, 1'b1, 4'd8, RW, "lui_wb");

        step(6'h04, 6'h00, 1'b1, 4'd0, v_if_go, "beq_if");
        step(6'h04, 6'h00, 1'b1, 4'd1, v_id, "beq_id");
        step(6'h04, 6'h00, 1'b1, 4'd4, SRCA | alu(4'd1) | ps(2'b01) | PWC, "beq_br");
        step(6'h05, 6'h00, 1'b1, 4'd0, v_if_go, "bne_if");
        step(6'h05, 6'h00, 1'b1, 4'd1, v_id, "bne_id");
        step(6'h05, 6'h00, 1'b1, 4'd4, SRCA | alu(4'd1) | ps(2'b01) | PWC, "bne_br");

        step(6'h02, 6'h00, 1'b1, 4'd0, v_if_go, "j_if");
        step(6'h02, 6'h00, 1'b1, 4'd1, v_id | PCW | ps(2'b10), "j_id");
        step(6'h02, 6'h00, 1'b1, 4'd8, 22'd0, "j_wb");
        step(6'h03, 6'h00, 1'b1, 4'd0, v_if_go, "jal_if");
        step(6'h03, 6'h00, 1'b1, 4'd1, v_id | PCW | ps(2'b10), "jal_id");
        step(6'h03, 6'h00, 1'b1, 4'd8, RW | SPC, "jal_wb");

        step(6'h00, 6'h08, 1'b1, 4'd0, v_if_go, "jr_if");
        step(6'h00, 6'h08, 1'b1, 4'd1, v_id, "jr_id");
        step(6'h00, 6'h08, 1'b1, 4'd10, SRCA | ps(2'b01) | PCW, "jr_jr");
        step(6'h00, 6'h09, 1'b1, 4'd0, v_if_go, "jalr_if");
        step(6'h00, 6'h09, 1'b1, 4'd1, v_id, "jalr_id");
        step(6'h00, 6'h09, 1'b1, 4'd10, SRCA | ps(2'b01) | PCW | RDST | RW | SPC, "jalr_jr");

        // Reset landing in the middle of a stalled load.
        step(6'h23, 6'h00, 1'b1, 4'd0, v_if_go, "rlw_if");
        step(6'h23, 6'h00, 1'b1, 4'd1, v_id, "rlw_id");
        step(6'h23, 6'h00, 1'b1, 4'd3, v_exi_se, "rlw_ex");
        step(6'h23, 6'h00, 1'b0, 4'd5, REQ | MRD | IORD, "rlw_memrd_wait");
        rst = 1'b1;
        step(6'h23, 6'h00, 1'b0, 4'd0, 22'd0, "rlw_mid_reset");
        rst = 1'b0;
        rtype(6'h21, 4'd0, "post_rst_addu");

        // Illegal opcode on both trap settings; this must stay the last sequence.
        step2(6'h3F, 1'b1, 4'd0, v_if_go, 4'd0, v_if_go, "ill_if");
        step2(6'h3F, 1'b1, 4'd1, v_id, 4'd1, v_id, "ill_id");
        step2(6'h3F, 1'b1, 4'd11, EXC | ps(2'b11) | PCW, 4'd3, v_exi_se, "ill_ex");
        step2(6'h3F, 1'b1, 4'd0, v_if_go, 4'd8, RW, "ill_next");

        @(negedge clk);
        #1;
        n_chk++;
        if (exp_q.size() != 0) begin
            n_fail++;
            $display("FAIL scoreboard_drain: got %0d pending, want 0", exp_q.size());
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/mc_ctrl_hs.md
MC_CTRL_HS -- requirements
Module: mc_ctrl_hs

Interface
REQ-001 Parameter ALUOP_W, default 4: ALU operation code width; codes come from the shared package, zero-extended to ALUOP_W.
REQ-002 Parameter EN_EXC, default 1: 1 enables the illegal-instruction trap; 0 decodes unknown opcodes as ADDIU.
REQ-003 clk  in  1  clock; all state updates on rising edge.
REQ-004 rst  in  1  reset, asynchronous, active-high.
REQ-005 opcode  in  6 and funct  in  6: instruction fields from IR.
REQ-006 mem_ready  in  1: memory completes the current request this cycle.
REQ-007 mem_req  out  1: memory access requested (IF, MEM_RD, MEM_WR).
REQ-008 Outputs: ALUOp out ALUOP_W; MemRead, MemWrite, IRWrite, RegDst, RegWrite, ALUSrcA, MemtoReg, PCWrite, PCWriteCond, IorD, SignExtend, SavePC out 1 each; ALUSrcB and PCSource out 2 each.
REQ-009 exc out 1: one-cycle pulse on an illegal instruction; state out 4: current FSM state for debug.

Function
REQ-010 States: IF=0, ID=1, EX_R=2, EX_I=3, BR=4, MEM_RD=5, MEM_WR=6, WB_R=7, WB_I=8, WB_MEM=9, JR=10, EXC=11; codes 12-15 go to IF next cycle with all outputs 0.
REQ-011 All outputs are combinational from state/opcode/funct/mem_ready; each defaults to 0 in every state unless stated.
REQ-012 IF: mem_req=1, MemRead=1, ALUOp=ADDU, ALUSrcB=01; if mem_ready=1, IRWrite=1 and PCWrite=1 and next state ID; else hold IF with IRWrite=PCWrite=0.
REQ-013 ID: ALUOp=ADDU, ALUSrcB=11, SignExtend=1.
REQ-014 ID next states: R-type with funct JR/JALR -> JR; other R-type -> EX_R; LW/SW/ALU-immediate -> EX_I; BEQ/BNE -> BR.
REQ-015 ID for J/JAL: PCSource=10, PCWrite=1, next WB_I.
REQ-016 ID for an unknown opcode: next EXC when EN_EXC=1, else EX_I.
REQ-017 EX_R: ALUSrcA=1, ALUOp decoded from funct (ADDU, SUBU, AND, OR, XOR, NOR, SLT, SLTU, SLL, SRL, SRA; others ADDU), next WB_R.
REQ-018 EX_I: ALUSrcA=1, ALUSrcB=10; SignExtend=0 only for ANDI/ORI/XORI.
REQ-019 EX_I ALUOp by opcode: LUI->LUI, ANDI->AND, ORI->OR, XORI->XOR, SLTI->SLT, SLTIU->SLTU, else ADDU.
REQ-020 EX_I next state: LW->MEM_RD, SW->MEM_WR, else WB_I.
REQ-021 BR: ALUSrcA=1, ALUSrcB=00, ALUOp=SUBU, PCSource=01, PCWriteCond=1, next IF; BEQ/BNE polarity is resolved in datapath.
REQ-022 MEM_RD: mem_req=1, MemRead=1, IorD=1; next WB_MEM when mem_ready=1, else hold.
REQ-023 MEM_WR: mem_req=1, MemWrite=1, IorD=1; next IF when mem_ready=1, else hold with MemWrite held at 1.
REQ-024 WB_R: RegDst=1, RegWrite=1, next IF.
REQ-025 WB_MEM: RegWrite=1, MemtoReg=1, next IF.
REQ-026 WB_I: RegWrite=1 except opcode J; SavePC=1 for JAL; next IF.
REQ-027 JR: ALUSrcA=1, PCSource=01, PCWrite=1; JALR additionally RegDst=1, RegWrite=1, SavePC=1; next IF.
REQ-028 EXC: exc=1, PCSource=11 (exception vector), PCWrite=1, no RegWrite or MemWrite, next IF.
REQ-029 No write strobe (PCWrite, IRWrite, RegWrite, MemWrite) is asserted for more than one cycle per instruction, except MemWrite during a MEM_WR wait.
REQ-030 Latency with mem_ready tied to 1, in cycles: R=4, LW=5, SW=4, I-ALU=4, BEQ/BNE=3, J/JAL=3, JR/JALR=3, illegal=3.
REQ-031 Each wait cycle adds exactly one cycle, in IF, MEM_RD or MEM_WR only.

Reset
REQ-032 rst=1 forces state=IF immediately, including mid-wait or mid-instruction.
REQ-033 While rst=1, all outputs are 0, including mem_req and exc.
REQ-034 After reset is released, the first rising edge evaluates IF.

Structure
REQ-035 The shared package mips_pkg holds the opcode, funct and ALU-operation constants and the state codes; the existing global constants are reused, not duplicated.
REQ-036 A single sub-module, alu_dec, maps funct/opcode to ALUOp and is instantiated twice (R-path and I-path); the FSM stays in mc_ctrl_hs.

Verification
REQ-037 Reset during MEM_RD with mem_ready=0: state=0 and MemRead=0 in the same cycle; the next instruction fetches normally.
REQ-038 ADDU (opcode 0, funct 0x21) with mem_ready=1: states 0,1,2,7; RegWrite=1 exactly in cycle 4.
REQ-039 LW with mem_ready low for 3 cycles in MEM_RD: state 5 held 4 cycles, then 9 with MemtoReg=1; total 8 cycles.
REQ-040 JAL: PCWrite=1 with PCSource=10 in ID, then WB_I with SavePC=1 and RegWrite=1; J has RegWrite=0 in WB_I.
REQ-041 JALR (funct 0x09): JR state with PCWrite=1, PCSource=01, SavePC=1, RegWrite=1.
REQ-042 Opcode 0x3F: EN_EXC=1 gives a one-cycle exc pulse and PCSource=11 in state 11; EN_EXC=0 takes path 0,1,3,8 with ALUOp=ADDU.
